// File: rtl/ct_split_buf_pkg.sv
// ct_split_buf_pkg: helpers shared by the ct_* split blocks.
// Holds the constant clog2 used to size pointers and counters.
package ct_split_buf_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/ct_split_buf_fifo.sv
// ct_fifo: single-clock show-ahead FIFO, one per split output.
// Head word is visible on rdata whenever empty is low.
module ct_fifo
  import ct_split_buf_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // A full FIFO refuses a push even when it pops this cycle.
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push  = wr && !full;
  assign pop   = rd && !empty;
  assign rdata = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ct_split_buf.sv
// ct_split_buf: buffered multicast split keyed by flow_id.
// Each output owns a show-ahead FIFO; a beat is written to all targets at once.
module ct_split_buf
  import ct_split_buf_pkg::*;
#(
  parameter int               NO           = 2,
  parameter int               WO           = 8,
  parameter int               NF           = 1,
  parameter int               WF           = 1,
  parameter logic [NF*WF-1:0] FLOWS        = '0,
  parameter logic [NF*NO-1:0] ENABLES      = '0,
  parameter int               DEPTH        = 2,
  parameter bit               DROP_UNKNOWN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WO-1:0]   i_data,
  input  logic            i_valid,
  input  logic [WF-1:0]   i_flow,
  output logic            o_ready,
  output logic [NO*WO-1:0] o_data,
  output logic [NO-1:0]   o_valid,
  output logic [NO*WF-1:0] o_flow,
  input  logic [NO-1:0]   i_ready,
  output logic            o_drop,
  output logic            o_error
);

  localparam int W = WO + WF;

  logic [NO-1:0]        en;
  logic [NO-1:0]        full;
  logic [NO-1:0]        empty;
  logic [NO-1:0][W-1:0] head;
  logic                 hit;
  logic                 push;

  // Duplicate flow entries simply OR their masks.
  always_comb begin
    en  = '0;
    hit = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (FLOWS[i*WF +: WF] == i_flow) begin
        en  = en | ENABLES[i*NO +: NO];
        hit = 1'b1;
      end
    end
  end

  // Only registered full flags feed o_ready, never i_ready.
  always_comb begin
    o_ready = 1'b0;
    o_drop  = 1'b0;
    if (!reset) begin
      o_ready = hit ? ~|(en & full) : DROP_UNKNOWN;
      o_drop  = i_valid && !hit && DROP_UNKNOWN;
    end
  end

  assign push    = i_valid && o_ready && hit;
  assign o_valid = ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      o_error <= 1'b0;
    else if (i_valid && !hit && !DROP_UNKNOWN)
      o_error <= 1'b1;
  end

  for (genvar k = 0; k < NO; k++) begin : g_out
    ct_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (push && en[k]),
      .wdata ({i_flow, i_data}),
      .rd    (o_valid[k] && i_ready[k]),
      .rdata (head[k]),
      .empty (empty[k]),
      .full  (full[k])
    );
    assign o_data[k*WO +: WO] = head[k][WO-1:0];
    assign o_flow[k*WF +: WF] = head[k][W-1:WO];
  end

endmodule

// File: tb/tb_ct_split_buf.sv
// tb_ct_split_buf: scoreboard bench for the buffered multicast split.
// Per-output expectation queues are filled by the driver and drained by a monitor.
module tb_ct_split_buf;

  localparam int NO    = 3;
  localparam int WO    = 8;
  localparam int NF    = 2;
  localparam int WF    = 4;
  localparam int DEPTH = 2;
  localparam logic [NF*WF-1:0] FLOWS   = {4'h5, 4'h2};
  localparam logic [NF*NO-1:0] ENABLES = {3'b110, 3'b011};

  logic           clk = 1'b0;
  logic           rst;
  logic [WO-1:0]  i_data;
  logic           i_valid;
  logic [WF-1:0]  i_flow;
  logic           o_ready;
  logic [NO*WO-1:0] o_data;
  logic [NO-1:0]  o_valid;
  logic [NO*WF-1:0] o_flow;
  logic [NO-1:0]  i_ready;
  logic           o_drop;
  logic           o_error;

  logic           s_rst;
  logic [WO-1:0]  s_data;
  logic           s_valid;
  logic [WF-1:0]  s_flow;
  logic           s_o_ready;
  logic [NO*WO-1:0] s_o_data;
  logic [NO-1:0]  s_o_valid;
  logic [NO*WF-1:0] s_o_flow;
  logic [NO-1:0]  s_ready;
  logic           s_o_drop;
  logic           s_o_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WF+WO-1:0] q [NO][$];

  always #5 clk = ~clk;

  ct_split_buf #(
    .NO(NO), .WO(WO), .NF(NF), .WF(WF),
    .FLOWS(FLOWS), .ENABLES(ENABLES),
    .DEPTH(DEPTH), .DROP_UNKNOWN(1'b1)
  ) dut (
    .clk(clk), .reset(rst),
    .i_data(i_data), .i_valid(i_valid), .i_flow(i_flow),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .o_flow(o_flow), .i_ready(i_ready),
    .o_drop(o_drop), .o_error(o_error)
  );

  ct_split_buf #(
    .NO(NO), .WO(WO), .NF(NF), .WF(WF),
    .FLOWS(FLOWS), .ENABLES(ENABLES),
    .DEPTH(DEPTH), .DROP_UNKNOWN(1'b0)
  ) dut_s (
    .clk(clk), .reset(s_rst),
    .i_data(s_data), .i_valid(s_valid), .i_flow(s_flow),
    .o_ready(s_o_ready), .o_data(s_o_data), .o_valid(s_o_valid),
    .o_flow(s_o_flow), .i_ready(s_ready),
    .o_drop(s_o_drop), .o_error(s_o_error)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit known(input logic [WF-1:0] f);
    return f == 4'h2 || f == 4'h5;
  endfunction

  function automatic logic [NO-1:0] targets(input logic [WF-1:0] f);
    if (f == 4'h2) return 3'b011;
    if (f == 4'h5) return 3'b110;
    return 3'b000;
  endfunction

  // One stimulus cycle; expected accept decided from model queue sizes.
  task automatic beat(input logic v, input logic [WF-1:0] f,
                      input logic [WO-1:0] d, input logic [NO-1:0] r);
    logic er;
    logic ed;
    logic [NO-1:0] m;
    @(negedge clk);
    i_valid = v;
    i_flow  = f;
    i_data  = d;
    i_ready = r;
    m  = targets(f);
    er = 1'b1;
    for (int k = 0; k < NO; k++)
      if (m[k] && q[k].size() >= DEPTH) er = 1'b0;
    ed = v && !known(f);
    #2;
    chk("o_ready", 32'(o_ready), 32'(er));
    chk("o_drop", 32'(o_drop), 32'(ed));
    if (v && er)
      for (int k = 0; k < NO; k++)
        if (m[k]) q[k].push_back({f, d});
  endtask

  always @(negedge clk) begin
    logic ev;
    #1;
    for (int k = 0; k < NO; k++) begin
      ev = q[k].size() != 0;
      chk($sformatf("o_valid%0d", k), 32'(o_valid[k]), 32'(ev));
      if (ev) begin
        chk($sformatf("head%0d", k),
            32'({o_flow[k*WF +: WF], o_data[k*WO +: WO]}), 32'(q[k][0]));
        if (i_ready[k]) void'(q[k].pop_front());
      end
    end
  end

  initial begin
    logic [WF-1:0] f;
    int r;
    rst = 1'b1; s_rst = 1'b1;
    i_valid = 1'b1; i_flow = 4'h7; i_data = 8'hFF; i_ready = '0;
    s_valid = 1'b0; s_flow = '0; s_data = '0; s_ready = '0;
    #3;
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_drop", 32'(o_drop), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_s_error", 32'(s_o_error), 0);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;

    beat(1'b1, 4'h2, 8'hA1, 3'b111);
    beat(1'b0, 4'h0, 8'h00, 3'b111);
    beat(1'b0, 4'h0, 8'h00, 3'b111);

    beat(1'b1, 4'h2, 8'h01, 3'b101);
    beat(1'b1, 4'h2, 8'h02, 3'b101);
    beat(1'b1, 4'h2, 8'h03, 3'b101);
    beat(1'b1, 4'h2, 8'h03, 3'b111);
    beat(1'b1, 4'h2, 8'h03, 3'b111);
    repeat (4) beat(1'b0, 4'h0, 8'h00, 3'b111);

    beat(1'b1, 4'h5, 8'h11, 3'b000);
    beat(1'b1, 4'h5, 8'h12, 3'b000);
    beat(1'b1, 4'h5, 8'h13, 3'b110);
    beat(1'b1, 4'h5, 8'h13, 3'b110);
    repeat (4) beat(1'b0, 4'h0, 8'h00, 3'b111);

    beat(1'b1, 4'h7, 8'hFF, 3'b111);
    beat(1'b0, 4'h7, 8'hFF, 3'b111);

    beat(1'b1, 4'h2, 8'hB1, 3'b101);
    beat(1'b1, 4'h2, 8'hB2, 3'b101);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NO; k++) q[k].delete();
    i_valid = 1'b1; i_flow = 4'h2; i_ready = 3'b000;
    #2;
    chk("midrst_ready", 32'(o_ready), 0);
    chk("midrst_valid", 32'(o_valid), 0);
    i_flow = 4'h7;
    #1;
    chk("midrst_drop", 32'(o_drop), 0);
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    repeat (2) beat(1'b0, 4'h0, 8'h00, 3'b000);
    beat(1'b1, 4'h5, 8'hC5, 3'b111);
    beat(1'b0, 4'h0, 8'h00, 3'b111);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) f = 4'h2;
      else if (r < 8) f = 4'h5;
      else f = 4'($urandom_range(0, 15));
      beat(1'($urandom_range(0, 1)), f, 8'($urandom_range(0, 255)),
           3'($urandom_range(0, 7)));
    end
    repeat (6) beat(1'b0, 4'h0, 8'h00, 3'b111);

    @(negedge clk);
    s_valid = 1'b1; s_flow = 4'h7; s_data = 8'hFF; s_ready = 3'b000;
    #2;
    chk("s_unk_ready", 32'(s_o_ready), 0);
    chk("s_unk_drop", 32'(s_o_drop), 0);
    chk("s_err_before", 32'(s_o_error), 0);
    @(negedge clk);
    #2;
    chk("s_err_set", 32'(s_o_error), 1);
    chk("s_unk_valid", 32'(s_o_valid), 0);
    s_flow = 4'h2; s_data = 8'h33;
    #1;
    chk("s_known_ready", 32'(s_o_ready), 1);
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    chk("s_err_sticky", 32'(s_o_error), 1);
    chk("s_valid", 32'(s_o_valid), 32'(3'b011));
    chk("s_head0", 32'({s_o_flow[3:0], s_o_data[7:0]}), 32'(12'h233));
    chk("s_head1", 32'({s_o_flow[7:4], s_o_data[15:8]}), 32'(12'h233));
    s_rst = 1'b1;
    #1;
    chk("s_err_rst", 32'(s_o_error), 0);
    chk("s_valid_rst", 32'(s_o_valid), 0);
    @(negedge clk);
    s_rst = 1'b0;
    #2;
    chk("s_err_after", 32'(s_o_error), 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
